rect_motion_ctrl: RTL and testbench

RECT_MOTION_CTRL -- requirements
Module: rect_motion_ctrl

---
 rtl/rect_motion_pkg.sv | 16 +
 rtl/rect_motion_ctrl_if.sv | 24 ++
 rtl/rect_motion_ctrl_axis.sv | 119 +++++++++++
 rtl/rect_motion_ctrl.sv | 109 ++++++++++
 tb/tb_rect_motion_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rect_motion_pkg.sv
// Shared constants and the per-axis state encoding for the rectangle motion controller.
package rect_motion_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int SPEED_W  = 4;
    localparam int POS_W    = 10;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        AXIS_IDLE   = 2'd0,
        AXIS_RAMP   = 2'd1,
        AXIS_CRUISE = 2'd2
    } axis_state_e;

endpackage

// File: rtl/rect_motion_ctrl_if.sv
// Sync/button inputs and rectangle outputs of the motion controller.
// The master side drives vsync/btn; the slave side is the controller.
interface rect_motion_ctrl_if;
    import rect_motion_pkg::*;

    logic             vsync;
    logic [3:0]       btn;          // {down, up, left, right}
    logic [POS_W-1:0] rect_x;
    logic [POS_W-1:0] rect_y;
    logic             moving;
    logic             edge_hit;
    logic             frame_tick;

    modport master (
        output vsync, btn,
        input  rect_x, rect_y, moving, edge_hit, frame_tick
    );

    modport slave (
        input  vsync, btn,
        output rect_x, rect_y, moving, edge_hit, frame_tick
    );

endinterface

// File: rtl/rect_motion_ctrl_axis.sv
// One motion axis: IDLE/RAMP/CRUISE speed FSM, position step and clamp to [0, LIMIT].
// All state advances only on tick; between ticks everything holds.
module motion_axis
    import rect_motion_pkg::*;
#(
    parameter int LIMIT        = 400,
    parameter int INIT         = 200,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_pos,
    input  logic             btn_neg,
    output logic [POS_W-1:0] pos,
    output logic             active_next,
    output logic             hit
);

    localparam logic signed [POS_W:0] LIMIT_S = (POS_W+1)'(LIMIT);
    localparam logic [SPEED_W-1:0]    MAX_SPD = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0]    SPD_ONE = SPEED_W'(1);
    localparam logic [CNT_W-1:0]      ACC_CNT = CNT_W'(ACCEL_FRAMES);

    axis_state_e        state_q, state_d;
    logic [SPEED_W-1:0] speed_q, speed_d, speed_n;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_n;
    logic               dir_neg_q, dir_neg_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic signed [POS_W:0] base_s, step_s, sum_s;

    // Next-state, speed ramp and clamped position for the current tick.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        speed_d   = speed_q;
        cnt_d     = cnt_q;
        dir_neg_d = dir_neg_q;
        pos_d     = pos_q;
        hit       = 1'b0;
        speed_n   = '0;
        cnt_n     = '0;
        base_s    = signed'({1'b0, pos_q});
        step_s    = '0;
        sum_s     = base_s;

        if (tick) begin
            if (btn_pos == btn_neg) begin
                // Neither or both held: stop without moving.
                state_d = AXIS_IDLE;
                speed_d = '0;
                cnt_d   = '0;
            end else begin
                // Starting from rest or reversing restarts the ramp at speed 1.
                if (state_q == AXIS_IDLE || btn_neg != dir_neg_q) begin
                    speed_n = SPD_ONE;
                    cnt_n   = '0;
                end else if (state_q == AXIS_RAMP) begin
                    cnt_n   = cnt_q + CNT_W'(1);
                    speed_n = speed_q;
                    if (cnt_n == ACC_CNT) begin
                        cnt_n   = '0;
                        speed_n = speed_q + SPD_ONE;
                    end
                end else begin
                    speed_n = speed_q;
                    cnt_n   = cnt_q;
                end

                step_s    = signed'({{(POS_W + 1 - SPEED_W){1'b0}}, speed_n});
                sum_s     = btn_neg ? (base_s - step_s) : (base_s + step_s);
                dir_neg_d = btn_neg;

                if (sum_s[POS_W]) begin
                    pos_d = '0;
                    hit   = 1'b1;
                end else if (sum_s > LIMIT_S) begin
                    pos_d = LIMIT_S[POS_W-1:0];
                    hit   = 1'b1;
                end else begin
                    pos_d = sum_s[POS_W-1:0];
                end

                if (hit) begin
                    state_d = AXIS_IDLE;
                    speed_d = '0;
                    cnt_d   = '0;
                end else begin
                    speed_d = speed_n;
                    cnt_d   = cnt_n;
                    state_d = (speed_n == MAX_SPD) ? AXIS_CRUISE : AXIS_RAMP;
                end
            end
        end
    end

    // Axis state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (reset) begin
            state_q   <= AXIS_IDLE;
            speed_q   <= '0;
            cnt_q     <= '0;
            dir_neg_q <= 1'b0;
            pos_q     <= POS_W'(INIT);
        end else begin
            state_q   <= state_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
            dir_neg_q <= dir_neg_d;
            pos_q     <= pos_d;
        end
    end

    assign pos         = pos_q;
    assign active_next = (state_d != AXIS_IDLE);

endmodule

// File: rtl/rect_motion_ctrl.sv
// Rectangle motion controller: synchronizes buttons and vsync, derives one frame tick
// per vsync rising edge and drives two motion axes from it.
module rect_motion_ctrl
    import rect_motion_pkg::*;
#(
    parameter int INIT_X       = 200,
    parameter int INIT_Y       = 100,
    parameter int RECT_W       = 240,
    parameter int RECT_H       = 100,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset,
    rect_motion_ctrl_if.slave  bus
);

    logic       vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
    logic       vs_prev_q, vs_prev_d;
    logic [1:0] sync_vld_q, sync_vld_d;
    logic [3:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic       frame_tick_q, frame_tick_d;
    logic       edge_hit_q, edge_hit_d;
    logic       moving_q, moving_d;

    logic [POS_W-1:0] x_pos, y_pos;
    logic             x_active_next, y_active_next;
    logic             x_hit, y_hit;

    // Synchronizer shifts, vsync edge detect and registered status outputs.
    always_comb begin
        vs_s1_d    = bus.vsync;
        vs_s2_d    = vs_s1_q;
        btn_s1_d   = bus.btn;
        btn_s2_d   = btn_s1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        // Until the vsync chain holds a post-reset sample, treat the previous level as
        // high so a vsync already high at reset release is not seen as a rising edge.
        vs_prev_d    = sync_vld_q[1] ? vs_s2_q : 1'b1;
        frame_tick_d = sync_vld_q[1] & vs_s2_q & ~vs_prev_q;
        edge_hit_d   = frame_tick_q & (x_hit | y_hit);
        moving_d     = frame_tick_q ? (x_active_next | y_active_next) : moving_q;
    end

    // Top-level registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            vs_prev_q    <= 1'b1;
            sync_vld_q   <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            frame_tick_q <= 1'b0;
            edge_hit_q   <= 1'b0;
            moving_q     <= 1'b0;
        end else begin
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            vs_prev_q    <= vs_prev_d;
            sync_vld_q   <= sync_vld_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            frame_tick_q <= frame_tick_d;
            edge_hit_q   <= edge_hit_d;
            moving_q     <= moving_d;
        end
    end

    motion_axis #(
        .LIMIT        (H_ACTIVE - RECT_W),
        .INIT         (INIT_X),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_axis_x (
        .clk         (clk),
        .reset       (reset),
        .tick        (frame_tick_q),
        .btn_pos     (btn_s2_q[0]),
        .btn_neg     (btn_s2_q[1]),
        .pos         (x_pos),
        .active_next (x_active_next),
        .hit         (x_hit)
    );

    // y grows downward, so "down" is the positive direction.
    motion_axis #(
        .LIMIT        (V_ACTIVE - RECT_H),
        .INIT         (INIT_Y),
        .MAX_SPEED    (MAX_SPEED),
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_axis_y (
        .clk         (clk),
        .reset       (reset),
        .tick        (frame_tick_q),
        .btn_pos     (btn_s2_q[3]),
        .btn_neg     (btn_s2_q[2]),
        .pos         (y_pos),
        .active_next (y_active_next),
        .hit         (y_hit)
    );

    assign bus.rect_x     = x_pos;
    assign bus.rect_y     = y_pos;
    assign bus.moving     = moving_q;
    assign bus.edge_hit   = edge_hit_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Scoreboard bench for rect_motion_ctrl: each frame pushes the model's expected
// position/status, and the entry is popped and compared after the DUT's frame tick.
module tb_rect_motion_ctrl;
    import rect_motion_pkg::*;

    localparam int INIT_X = 200;
    localparam int INIT_Y = 100;
    localparam int RECT_W = 240;
    localparam int RECT_H = 100;
    localparam int MAXSPD = 8;
    localparam int ACCEL  = 4;
    localparam int LIM_X  = 640 - RECT_W;
    localparam int LIM_Y  = 480 - RECT_H;

    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_RIGHT = 4'b0001;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_UP    = 4'b0100;
    localparam logic [3:0] B_DOWN  = 4'b1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rect_motion_ctrl_if bus();

    rect_motion_ctrl #(
        .INIT_X(INIT_X), .INIT_Y(INIT_Y), .RECT_W(RECT_W), .RECT_H(RECT_H),
        .MAX_SPEED(MAXSPD), .ACCEL_FRAMES(ACCEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int pos; int spd; int cnt; int dir; } axis_m_t;
    typedef struct { int x; int y; bit moving; bit hit; } exp_t;

    int      vectors     = 0;
    int      miscompares = 0;
    exp_t    sb[$];
    axis_m_t mx, my;
    bit      last_hit;

    // Reference behaviour of one axis for one frame tick with direction d.
    function automatic axis_m_t model_step(input axis_m_t a, input int d, input int lim,
                                           output bit hit);
        axis_m_t r = a;
        int np;
        hit = 1'b0;
        if (d == 0) begin
            r.spd = 0; r.cnt = 0; r.dir = 0;
        end else begin
            if (a.spd == 0 || d != a.dir) begin
                r.spd = 1; r.cnt = 0;
            end else if (a.spd < MAXSPD) begin
                r.cnt = a.cnt + 1;
                if (r.cnt == ACCEL) begin r.spd = a.spd + 1; r.cnt = 0; end
            end
            r.dir = d;
            np = a.pos + d * r.spd;
            if (np < 0)   begin np = 0;   hit = 1'b1; end
            if (np > lim) begin np = lim; hit = 1'b1; end
            if (hit) begin r.spd = 0; r.cnt = 0; r.dir = 0; end
            r.pos = np;
        end
        return r;
    endfunction

    task automatic model_reset();
        mx = '{INIT_X, 0, 0, 0};
        my = '{INIT_Y, 0, 0, 0};
        sb.delete();
    endtask

    // One frame: hold buttons b, pulse vsync, compare the update after frame_tick.
    task automatic frame(input logic [3:0] b);
        bit   hx, hy;
        int   dx, dy, lat;
        exp_t e;
        dx = (b[0] && !b[1]) ? 1 : ((b[1] && !b[0]) ? -1 : 0);
        dy = (b[3] && !b[2]) ? 1 : ((b[2] && !b[3]) ? -1 : 0);
        mx = model_step(mx, dx, LIM_X, hx);
        my = model_step(my, dy, LIM_Y, hy);
        e.x = mx.pos; e.y = my.pos;
        e.moving = (mx.spd != 0) || (my.spd != 0);
        e.hit = hx | hy;
        sb.push_back(e);

        bus.btn = b;
        repeat (3) @(negedge clk);
        bus.vsync = 1'b1;
        @(negedge clk);
        bus.vsync = 1'b0;
        lat = 1;
        while (!bus.frame_tick && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (!bus.frame_tick) begin
            miscompares++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles", lat);
            void'(sb.pop_front());
            return;
        end
        if (lat != 3) begin
            miscompares++;
            $display("FAIL tick_latency: got %0d cycles, expected 3", lat);
        end

        @(negedge clk);
        e = sb.pop_front();
        last_hit = bus.edge_hit;
        vectors += 5;
        if (bus.rect_x !== 10'(e.x)) begin
            miscompares++; $display("FAIL rect_x: got %0d, expected %0d", bus.rect_x, e.x);
        end
        if (bus.rect_y !== 10'(e.y)) begin
            miscompares++; $display("FAIL rect_y: got %0d, expected %0d", bus.rect_y, e.y);
        end
        if (bus.moving !== e.moving) begin
            miscompares++; $display("FAIL moving: got %b, expected %b", bus.moving, e.moving);
        end
        if (bus.edge_hit !== e.hit) begin
            miscompares++; $display("FAIL edge_hit: got %b, expected %b", bus.edge_hit, e.hit);
        end
        if (bus.frame_tick !== 1'b0) begin
            miscompares++; $display("FAIL tick_width: frame_tick still %b", bus.frame_tick);
        end

        @(negedge clk);
        vectors += 2;
        if (bus.edge_hit !== 1'b0) begin
            miscompares++; $display("FAIL edge_hit_width: got %b, expected 0", bus.edge_hit);
        end
        if (bus.rect_x !== 10'(e.x)) begin
            miscompares++; $display("FAIL x_hold: got %0d, expected %0d", bus.rect_x, e.x);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.vsync = 1'b0; bus.btn = B_NONE;
        model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vectors += 5;
        if (bus.rect_x !== 10'(INIT_X)) begin
            miscompares++; $display("FAIL reset_x: got %0d, expected %0d", bus.rect_x, INIT_X);
        end
        if (bus.rect_y !== 10'(INIT_Y)) begin
            miscompares++; $display("FAIL reset_y: got %0d, expected %0d", bus.rect_y, INIT_Y);
        end
        if (bus.moving !== 1'b0) begin
            miscompares++; $display("FAIL reset_moving: got %b, expected 0", bus.moving);
        end
        if (bus.edge_hit !== 1'b0) begin
            miscompares++; $display("FAIL reset_edge_hit: got %b, expected 0", bus.edge_hit);
        end
        if (bus.frame_tick !== 1'b0) begin
            miscompares++; $display("FAIL reset_tick: got %b, expected 0", bus.frame_tick);
        end
    endtask

    task automatic test_idle_frames();
        repeat (3) frame(B_NONE);
    endtask

    task automatic test_wide_vsync();
        int  ticks = 0;
        bit  h;
        mx = model_step(mx, 0, LIM_X, h);
        my = model_step(my, 0, LIM_Y, h);
        bus.btn = B_NONE;
        @(negedge clk);
        bus.vsync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 7) bus.vsync = 1'b0;
            if (bus.frame_tick) ticks++;
        end
        vectors += 2;
        if (ticks != 1) begin
            miscompares++; $display("FAIL wide_vsync_ticks: got %0d, expected 1", ticks);
        end
        if (bus.rect_x !== 10'(mx.pos)) begin
            miscompares++; $display("FAIL wide_vsync_x: got %0d, expected %0d", bus.rect_x, mx.pos);
        end
    endtask

    task automatic test_both_lr();
        repeat (2) frame(B_LEFT | B_RIGHT);
        vectors += 3;
        if (bus.rect_x !== 10'd200) begin
            miscompares++; $display("FAIL both_lr_x: got %0d, expected 200", bus.rect_x);
        end
        if (dut.u_axis_x.state_q !== AXIS_IDLE) begin
            miscompares++; $display("FAIL both_lr_state: got %0d, expected IDLE", dut.u_axis_x.state_q);
        end
        if (bus.moving !== 1'b0) begin
            miscompares++; $display("FAIL both_lr_moving: got %b, expected 0", bus.moving);
        end
    endtask

    task automatic test_ramp();
        repeat (9) frame(B_RIGHT);
        vectors += 3;
        if (bus.rect_x !== 10'd215) begin
            miscompares++; $display("FAIL ramp_x: got %0d, expected 215", bus.rect_x);
        end
        if (dut.u_axis_x.state_q !== AXIS_RAMP) begin
            miscompares++; $display("FAIL ramp_state: got %0d, expected RAMP", dut.u_axis_x.state_q);
        end
        if (bus.moving !== 1'b1) begin
            miscompares++; $display("FAIL ramp_moving: got %b, expected 1", bus.moving);
        end
    endtask

    task automatic test_clamp_right();
        int guard = 0;
        frame(B_NONE);
        repeat (5) begin frame(B_RIGHT); frame(B_NONE); end
        repeat (29) frame(B_RIGHT);
        while (mx.pos < 396 && guard < 20) begin frame(B_RIGHT); guard++; end
        vectors += 2;
        if (bus.rect_x !== 10'd396) begin
            miscompares++; $display("FAIL pre_clamp_x: got %0d, expected 396", bus.rect_x);
        end
        if (dut.u_axis_x.state_q !== AXIS_CRUISE) begin
            miscompares++; $display("FAIL cruise_state: got %0d, expected CRUISE", dut.u_axis_x.state_q);
        end
        frame(B_RIGHT);
        vectors += 3;
        if (bus.rect_x !== 10'd400) begin
            miscompares++; $display("FAIL clamp_x: got %0d, expected 400", bus.rect_x);
        end
        if (last_hit !== 1'b1) begin
            miscompares++; $display("FAIL clamp_hit: got %b, expected 1", last_hit);
        end
        if (dut.u_axis_x.state_q !== AXIS_IDLE) begin
            miscompares++; $display("FAIL clamp_state: got %0d, expected IDLE", dut.u_axis_x.state_q);
        end
        frame(B_RIGHT);
        vectors += 3;
        if (bus.rect_x !== 10'd400) begin
            miscompares++; $display("FAIL limit_x: got %0d, expected 400", bus.rect_x);
        end
        if (last_hit !== 1'b1) begin
            miscompares++; $display("FAIL limit_hit: got %b, expected 1", last_hit);
        end
        if (dut.u_axis_x.state_q !== AXIS_IDLE) begin
            miscompares++; $display("FAIL limit_state: got %0d, expected IDLE", dut.u_axis_x.state_q);
        end
    endtask

    task automatic test_clamp_up();
        repeat (24) frame(B_UP);
        frame(B_NONE);
        repeat (2) begin frame(B_UP); frame(B_NONE); end
        repeat (8) frame(B_UP);
        vectors++;
        if (bus.rect_y !== 10'd2) begin
            miscompares++; $display("FAIL pre_top_y: got %0d, expected 2", bus.rect_y);
        end
        frame(B_UP);
        vectors += 2;
        if (bus.rect_y !== 10'd0) begin
            miscompares++; $display("FAIL top_y: got %0d, expected 0", bus.rect_y);
        end
        if (last_hit !== 1'b1) begin
            miscompares++; $display("FAIL top_hit: got %b, expected 1", last_hit);
        end
        frame(B_DOWN);
        vectors++;
        if (bus.rect_y !== 10'd1) begin
            miscompares++; $display("FAIL down_y: got %0d, expected 1", bus.rect_y);
        end
    endtask

    task automatic test_reset_cruise();
        int guard = 0;
        int ticks = 0;
        while (mx.pos > 184 && guard < 60) begin frame(B_LEFT); guard++; end
        frame(B_NONE);
        guard = 0;
        while (mx.pos > 180 && guard < 10) begin frame(B_LEFT); frame(B_NONE); guard++; end
        repeat (29) frame(B_RIGHT);
        vectors += 2;
        if (bus.rect_x !== 10'd300) begin
            miscompares++; $display("FAIL cruise300_x: got %0d, expected 300", bus.rect_x);
        end
        if (dut.u_axis_x.state_q !== AXIS_CRUISE) begin
            miscompares++; $display("FAIL cruise300_state: got %0d, expected CRUISE", dut.u_axis_x.state_q);
        end

        bus.btn = B_NONE;
        bus.vsync = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        vectors += 3;
        if (bus.rect_x !== 10'(INIT_X)) begin
            miscompares++; $display("FAIL mid_reset_x: got %0d, expected %0d", bus.rect_x, INIT_X);
        end
        if (bus.rect_y !== 10'(INIT_Y)) begin
            miscompares++; $display("FAIL mid_reset_y: got %0d, expected %0d", bus.rect_y, INIT_Y);
        end
        if (bus.moving !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_moving: got %b, expected 0", bus.moving);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.frame_tick) ticks++;
        end
        vectors++;
        if (ticks != 0) begin
            miscompares++; $display("FAIL stale_vsync_ticks: got %0d, expected 0", ticks);
        end
        bus.vsync = 1'b0;
        repeat (3) @(negedge clk);
        frame(B_NONE);
        frame(B_DOWN);
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_wide_vsync();
        test_both_lr();
        test_ramp();
        test_clamp_right();
        test_clamp_up();
        test_reset_cruise();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
